// File: rtl/universal_register_negclk.sv
// rtl/universal_register_negclk.sv - falling-edge universal register: load, shift, rotate, count, carry/zero status
// Optional synchronous clear port SClrN is enabled by defining URNC_SYNC_CLEAR_EN.
module universal_register_negclk #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             ClkN,
    input  logic             ClrN,
`ifdef URNC_SYNC_CLEAR_EN
    input  logic             SClrN,
`endif
    input  logic             Enbar,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] new_data,
    input  logic             SerIn,
    output logic [WIDTH-1:0] register,
    output logic             SerOut,
    output logic             Carry,
    output logic             Zero
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_DEC  = 3'b111;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] reg_next;
    logic             carry_next;

    always_comb begin
        reg_next   = register;
        carry_next = Carry;
        if (!Enbar) begin
            case (Mode)
                MODE_HOLD: begin
                    reg_next   = register;
                    carry_next = Carry;
                end
                MODE_LOAD: begin
                    reg_next   = new_data;
                    carry_next = 1'b0;
                end
                MODE_SHL: begin
                    reg_next   = {register[WIDTH-2:0], SerIn};
                    carry_next = register[WIDTH-1];
                end
                MODE_SHR: begin
                    reg_next   = {SerIn, register[WIDTH-1:1]};
                    carry_next = register[0];
                end
                MODE_ROL: begin
                    reg_next   = {register[WIDTH-2:0], register[WIDTH-1]};
                    carry_next = register[WIDTH-1];
                end
                MODE_ROR: begin
                    reg_next   = {register[0], register[WIDTH-1:1]};
                    carry_next = register[0];
                end
                // Carry flags the wrap: all-ones on increment, zero on decrement.
                MODE_INC: begin
                    reg_next   = register + ONE;
                    carry_next = &register;
                end
                MODE_DEC: begin
                    reg_next   = register - ONE;
                    carry_next = ~|register;
                end
                default: begin
                    reg_next   = register;
                    carry_next = Carry;
                end
            endcase
        end
`ifdef URNC_SYNC_CLEAR_EN
        if (!SClrN) begin
            reg_next   = RESET_VALUE;
            carry_next = 1'b0;
        end
`endif
    end

    always_ff @(negedge ClkN or negedge ClrN) begin
        if (!ClrN) begin
            register <= RESET_VALUE;
            Carry    <= 1'b0;
        end else begin
            register <= reg_next;
            Carry    <= carry_next;
        end
    end

    assign SerOut = ((Mode == MODE_SHL) || (Mode == MODE_ROL)) ? register[WIDTH-1] : register[0];
    assign Zero   = (register == {WIDTH{1'b0}});

endmodule

// File: tb/tb_universal_register_negclk.sv
// tb/tb_universal_register_negclk.sv - randomized and directed bench for universal_register_negclk
module tb_universal_register_negclk;

    logic       ClkN;
    logic       ClrN;
    logic       SClrN;
    logic       Enbar;
    logic [2:0] Mode;
    logic [7:0] new_data;
    logic       SerIn;
    logic [7:0] register;
    logic       SerOut;
    logic       Carry;
    logic       Zero;

    int n_checks = 0;
    int n_fail   = 0;

    int m_reg;
    int m_carry;

    universal_register_negclk #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .ClkN     (ClkN),
        .ClrN     (ClrN),
`ifdef URNC_SYNC_CLEAR_EN
        .SClrN    (SClrN),
`endif
        .Enbar    (Enbar),
        .Mode     (Mode),
        .new_data (new_data),
        .SerIn    (SerIn),
        .register (register),
        .SerOut   (SerOut),
        .Carry    (Carry),
        .Zero     (Zero)
    );

    initial ClkN = 1'b1;
    always #5 ClkN = ~ClkN;

    // Arithmetic reference of one enabled operation on an 8-bit value.
    task automatic model_step(input int mode, input int data, input int ser);
        int r;
        r = m_reg;
        case (mode)
            1: begin m_reg = data;                        m_carry = 0; end
            2: begin m_reg = (r * 2 + ser) % 256;         m_carry = r / 128; end
            3: begin m_reg = r / 2 + ser * 128;           m_carry = r % 2; end
            4: begin m_reg = (r * 2) % 256 + r / 128;     m_carry = r / 128; end
            5: begin m_reg = r / 2 + (r % 2) * 128;       m_carry = r % 2; end
            6: begin m_reg = (r + 1) % 256;               m_carry = (r == 255) ? 1 : 0; end
            7: begin m_reg = (r + 255) % 256;             m_carry = (r == 0) ? 1 : 0; end
            default: ;
        endcase
    endtask

    function automatic int model_serout(input int mode);
        if (mode == 2 || mode == 4) return m_reg / 128;
        return m_reg % 2;
    endfunction

    // Drives inputs after a rising edge, lets one falling edge pass, returns 1 unit later.
    task automatic tick(input logic en_n, input logic [2:0] mode, input logic [7:0] data,
                        input logic ser, input logic sclr_n);
        @(posedge ClkN);
        #1;
        Enbar    = en_n;
        Mode     = mode;
        new_data = data;
        SerIn    = ser;
        SClrN    = sclr_n;
        @(negedge ClkN);
`ifdef URNC_SYNC_CLEAR_EN
        if (!sclr_n) begin
            m_reg   = 0;
            m_carry = 0;
        end else if (!en_n) model_step(int'(mode), int'(data), int'(ser));
`else
        if (!en_n) model_step(int'(mode), int'(data), int'(ser));
`endif
        #1;
    endtask

    task automatic test_reset;
        ClrN = 1'b0; SClrN = 1'b1; Enbar = 1'b0; Mode = 3'b001; new_data = 8'h55; SerIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ClkN);
            #1;
            n_checks++;
            if (register !== 8'h00 || Carry !== 1'b0 || Zero !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold: reg=%h carry=%b zero=%b required reg=00 carry=0 zero=1",
                         register, Carry, Zero);
            end
        end
        #1 ClrN = 1'b1;
        @(negedge ClkN);
        #1;
        m_reg = 8'h55; m_carry = 0;
        n_checks++;
        if (register !== 8'h55 || Carry !== 1'b0 || Zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: reg=%h carry=%b zero=%b required reg=55 carry=0 zero=0",
                     register, Carry, Zero);
        end
    endtask

    task automatic test_enable_gating;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 3'b001, 8'hAA, 1'b0, 1'b1);
            n_checks++;
            if (register !== 8'h55) begin
                n_fail++;
                $display("FAIL enable_gated: reg=%h required 55", register);
            end
        end
        tick(1'b0, 3'b001, 8'hAA, 1'b0, 1'b1);
        n_checks++;
        if (register !== 8'hAA || Carry !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_load: reg=%h carry=%b required AA 0", register, Carry);
        end
    endtask

    task automatic test_shift;
        tick(1'b0, 3'b001, 8'h81, 1'b0, 1'b1);
        tick(1'b0, 3'b010, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (register !== 8'h02 || Carry !== 1'b1) begin
            n_fail++;
            $display("FAIL shift_left: reg=%h carry=%b required 02 1", register, Carry);
        end
        tick(1'b0, 3'b011, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if (register !== 8'h81 || Carry !== 1'b0) begin
            n_fail++;
            $display("FAIL shift_right: reg=%h carry=%b required 81 0", register, Carry);
        end
    endtask

    task automatic test_rotate;
        tick(1'b0, 3'b101, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (register !== 8'hC0 || Carry !== 1'b1) begin
            n_fail++;
            $display("FAIL rotate_right: reg=%h carry=%b required C0 1", register, Carry);
        end
        tick(1'b0, 3'b001, 8'h81, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b0, 3'b100, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (register !== 8'h81 || Carry !== 1'b1) begin
            n_fail++;
            $display("FAIL rotate_left_8: reg=%h carry=%b required 81 1", register, Carry);
        end
    endtask

    task automatic test_counter_wrap;
        tick(1'b0, 3'b001, 8'hFE, 1'b0, 1'b1);
        tick(1'b0, 3'b110, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (register !== 8'hFF || Carry !== 1'b0) begin
            n_fail++;
            $display("FAIL inc_to_ff: reg=%h carry=%b required FF 0", register, Carry);
        end
        tick(1'b0, 3'b110, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (register !== 8'h00 || Carry !== 1'b1 || Zero !== 1'b1) begin
            n_fail++;
            $display("FAIL inc_wrap: reg=%h carry=%b zero=%b required 00 1 1", register, Carry, Zero);
        end
        tick(1'b0, 3'b111, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (register !== 8'hFF || Carry !== 1'b1 || Zero !== 1'b0) begin
            n_fail++;
            $display("FAIL dec_wrap: reg=%h carry=%b zero=%b required FF 1 0", register, Carry, Zero);
        end
    endtask

    task automatic test_async_clear;
        tick(1'b0, 3'b001, 8'h10, 1'b0, 1'b1);
        tick(1'b0, 3'b110, 8'h00, 1'b0, 1'b1);
        tick(1'b0, 3'b110, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (register !== 8'h12) begin
            n_fail++;
            $display("FAIL count_before_clear: reg=%h required 12", register);
        end
        ClrN = 1'b0;
        #1;
        n_checks++;
        if (register !== 8'h00 || Carry !== 1'b0 || Zero !== 1'b1) begin
            n_fail++;
            $display("FAIL async_clear: reg=%h carry=%b zero=%b required 00 0 1", register, Carry, Zero);
        end
        ClrN = 1'b1;
        m_reg = 0; m_carry = 0;
        tick(1'b0, 3'b110, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (register !== 8'h01 || Carry !== 1'b0) begin
            n_fail++;
            $display("FAIL count_after_clear: reg=%h carry=%b required 01 0", register, Carry);
        end
    endtask

`ifdef URNC_SYNC_CLEAR_EN
    task automatic test_sync_clear;
        tick(1'b0, 3'b001, 8'h33, 1'b0, 1'b1);
        tick(1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (register !== 8'h00 || Carry !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_clear: reg=%h carry=%b required 00 0", register, Carry);
        end
        SClrN = 1'b1;
    endtask
`endif

    task automatic test_serout;
        tick(1'b0, 3'b001, 8'h80, 1'b0, 1'b1);
        Enbar = 1'b1;
        for (int m = 0; m < 8; m++) begin
            Mode = 3'(m);
            #1;
            n_checks++;
            if (SerOut !== ((m == 2 || m == 4) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL serout_mode%0d: serout=%b required %b", m, SerOut,
                         (m == 2 || m == 4) ? 1'b1 : 1'b0);
            end
        end
    endtask

    task automatic test_random;
        logic       en_n;
        logic [2:0] mode;
        for (int i = 0; i < 300; i++) begin
            en_n = ($urandom_range(0, 3) == 0);
            mode = 3'($urandom_range(0, 7));
            tick(en_n, mode, 8'($urandom), 1'($urandom), 1'b1);
            n_checks++;
            if (register !== 8'(m_reg) || Carry !== 1'(m_carry) || Zero !== (m_reg == 0) ||
                SerOut !== 1'(model_serout(int'(mode)))) begin
                n_fail++;
                $display("FAIL random_%0d: reg=%h carry=%b zero=%b serout=%b required %h %0d %0d %0d",
                         i, register, Carry, Zero, SerOut, 8'(m_reg), m_carry, (m_reg == 0),
                         model_serout(int'(mode)));
            end
        end
    endtask

    initial begin
        m_reg = 0; m_carry = 0;
        test_reset;
        test_enable_gating;
        test_shift;
        test_rotate;
        test_counter_wrap;
        test_async_clear;
`ifdef URNC_SYNC_CLEAR_EN
        test_sync_clear;
`endif
        test_serout;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
